// File: rtl/memory_stage_if.sv
// Data-memory request/response bus used by the MEM stage.
//   master (MEM stage): req, we, addr, wdata, wstrb out; ready, rdata in
//   slave  (memory)   : the mirror image
// addr is doubleword aligned, wstrb selects byte lanes, and rdata is valid with ready.
interface memory_stage_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned STRB_W = XLEN / 8
);
  logic              req;
  logic              we;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic [STRB_W-1:0] wstrb;
  logic              ready;
  logic [XLEN-1:0]   rdata;

  modport master (output req, we, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input req, we, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/memory_stage.sv
// Pipeline MEM stage. Performs the load or store of the instruction held in
// the mem_* registers over the dmem bus. It formats load data, which is sign-
// or zero-extended, and registers the results into wb_*.
//   clk, rst       : clock, asynchronous active-high reset
//   mem_*          : EXE->MEM pipeline registers (held by mem_stall)
//   wb_stall       : writeback cannot accept this cycle
//   mem_stall      : combinational hold request back to EXE
//   dmem           : data-memory bus (master side)
//   wb_*           : registered MEM->WB pipeline registers
module memory_stage #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_V,
  input  logic [31:0]       mem_IR,
  input  logic [XLEN-1:0]   mem_PC,
  input  logic [XLEN-1:0]   mem_ALU_RESULT,
  input  logic [XLEN-1:0]   mem_SR2,
  input  logic [XLEN-1:0]   mem_CSRFD,
  input  logic [XLEN-1:0]   mem_RFD,
  input  logic              wb_stall,
  output logic              mem_stall,
  memory_stage_if.master    dmem,
  output logic              wb_V,
  output logic [31:0]       wb_IR,
  output logic [XLEN-1:0]   wb_PC,
  output logic [XLEN-1:0]   wb_ALU_RESULT,
  output logic [XLEN-1:0]   wb_CSRFD,
  output logic [XLEN-1:0]   wb_RFD,
  output logic [XLEN-1:0]   wb_MEM_DATA,
  output logic              wb_MISALIGN
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, next_state;
  logic              req_q;
  logic [XLEN-1:0]   load_buf;

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [2:0]        off;
  logic [5:0]        lane_shift;
  logic              is_load, is_store, memop, misalign, aligned_op;
  logic [STRB_W-1:0] store_strb;
  logic [XLEN-1:0]   rdata_shifted, load_fmt;
  logic              wb_capture, wb_bubble;

  // Instruction decode; f3[1:0] gives the access size for both loads and stores
  assign opcode     = mem_IR[6:0];
  assign f3         = mem_IR[14:12];
  assign off        = mem_ALU_RESULT[2:0];
  assign lane_shift = {off, 3'b000};
  assign is_load    = (opcode == OPC_LOAD);
  assign is_store   = (opcode == OPC_STORE);
  assign memop      = mem_V & (is_load | is_store);
  assign aligned_op = memop & ~misalign;

  // Natural-alignment check per access size
  always_comb begin
    misalign = 1'b0;
    unique case (f3[1:0])
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = off[0];
      2'b10:   misalign = |off[1:0];
      default: misalign = |off;
    endcase
  end

  // Store byte enables, placed on the lane selected by the low address bits
  always_comb begin
    store_strb = '0;
    unique case (f3[1:0])
      2'b00:   store_strb = STRB_W'(8'h01) << off;
      2'b01:   store_strb = STRB_W'(8'h03) << off;
      2'b10:   store_strb = STRB_W'(8'h0F) << off;
      default: store_strb = '1;
    endcase
  end

  // Bus fields follow mem_* directly; EXE holds them stable while we stall
  assign dmem.req   = req_q;
  assign dmem.we    = is_store;
  assign dmem.addr  = {mem_ALU_RESULT[XLEN-1:3], 3'b000};
  assign dmem.wdata = mem_SR2 << lane_shift;
  assign dmem.wstrb = is_store ? store_strb : '0;

  // Load formatting: bring the addressed lane down to bit 0, then extend
  assign rdata_shifted = dmem.rdata >> lane_shift;

  always_comb begin
    load_fmt = rdata_shifted;
    unique case (f3)
      3'b000:  load_fmt = {{(XLEN-8){rdata_shifted[7]}},   rdata_shifted[7:0]};
      3'b001:  load_fmt = {{(XLEN-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b010:  load_fmt = {{(XLEN-32){rdata_shifted[31]}}, rdata_shifted[31:0]};
      3'b100:  load_fmt = {{(XLEN-8){1'b0}},  rdata_shifted[7:0]};
      3'b101:  load_fmt = {{(XLEN-16){1'b0}}, rdata_shifted[15:0]};
      3'b110:  load_fmt = {{(XLEN-32){1'b0}}, rdata_shifted[31:0]};
      default: load_fmt = rdata_shifted;
    endcase
  end

  // Next state, stall and writeback selection
  always_comb begin
    next_state = state;
    mem_stall  = wb_stall | (aligned_op & (state != DONE));
    wb_capture = 1'b0;
    wb_bubble  = 1'b0;
    unique case (state)
      IDLE: begin
        if (aligned_op) begin
          next_state = BUSY;
          wb_bubble  = ~wb_stall;
        end else begin
          wb_capture = ~wb_stall;
        end
      end
      BUSY: begin
        wb_bubble = ~wb_stall;
        if (dmem.ready) next_state = DONE;
      end
      DONE: begin
        if (!wb_stall) begin
          next_state = IDLE;
          wb_capture = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register; req is high exactly while BUSY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      req_q <= 1'b0;
    end else begin
      state <= next_state;
      req_q <= (next_state == BUSY);
    end
  end

  // Formatted load data captured on completion; stores leave zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_buf <= '0;
    end else if ((state == BUSY) && dmem.ready) begin
      load_buf <= is_load ? load_fmt : '0;
    end
  end

  // MEM->WB pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_V          <= 1'b0;
      wb_IR         <= '0;
      wb_PC         <= '0;
      wb_ALU_RESULT <= '0;
      wb_CSRFD      <= '0;
      wb_RFD        <= '0;
      wb_MEM_DATA   <= '0;
      wb_MISALIGN   <= 1'b0;
    end else if (wb_capture) begin
      wb_V          <= mem_V;
      wb_IR         <= mem_IR;
      wb_PC         <= mem_PC;
      wb_ALU_RESULT <= mem_ALU_RESULT;
      wb_CSRFD      <= mem_CSRFD;
      wb_RFD        <= mem_RFD;
      wb_MEM_DATA   <= (state == DONE) ? load_buf : '0;
      wb_MISALIGN   <= (state == IDLE) & memop & misalign;
    end else if (wb_bubble) begin
      wb_V <= 1'b0;
    end
  end

endmodule
